// File: rtl/data_bank_arbiter_pkg.sv
// Shared sizing constants, state encoding and small helpers for the data bank arbiter.
package data_bank_arbiter_pkg;

   localparam int NREQ      = 3;
   localparam int DW        = 8;
   localparam int DEPTH     = 4;
   localparam int AW        = $clog2(DEPTH);
   localparam int IW        = $clog2(NREQ);
   localparam int MAX_BURST = 4;
   localparam int CW        = $clog2(MAX_BURST + 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } state_t;

   // Requester index to one-hot vector.
   function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IW-1:0] idx);
      logic [NREQ-1:0] oh;
      oh = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         oh[i] = (idx == IW'(i));
      end
      return oh;
   endfunction

   // One-hot vector to requester index (zero when no bit is set).
   function automatic logic [IW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [IW-1:0] idx;
      idx = {IW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) begin
            idx = IW'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Burst counter increment that sticks at MAX_BURST.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
      if (cnt >= CW'(MAX_BURST)) begin
         return CW'(MAX_BURST);
      end else begin
         return cnt + CW'(1);
      end
   endfunction

endpackage

// File: rtl/data_bank_arbiter_rr_pick.sv
// Round-robin picker: first set request bit searching from last+1 upward, wrapping.
module rr_pick
   import data_bank_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] pick
);

   logic          found_s;
   logic [IW-1:0] idx_s;

   // Rotate the search origin to last+1 and take the first requester found.
   always_comb begin
      pick    = {NREQ{1'b0}};
      found_s = 1'b0;
      idx_s   = {IW{1'b0}};
      for (int k = 1; k <= NREQ; k++) begin
         idx_s = IW'((int'(last) + k) % NREQ);
         if (!found_s && req[idx_s]) begin
            pick[idx_s] = 1'b1;
            found_s     = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/data_bank_arbiter.sv
// Shared 8-bit register bank with round-robin, burst-limited access arbitration.
module data_bank_arbiter
   import data_bank_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [DW-1:0]      rdata,
   output logic [NREQ-1:0]    rvalid,
   output logic               busy
);

   state_t          state_r;
   logic [IW-1:0]   owner_r;
   logic [CW-1:0]   burst_cnt_r;
   logic [IW-1:0]   last_r;
   logic [DW-1:0]   bank_r [DEPTH];
   logic [DW-1:0]   rdata_r;
   logic [NREQ-1:0] rvalid_r;

   logic [NREQ-1:0] pick_s;
   logic [NREQ-1:0] owner_oh_s;
   logic            other_req_s;
   logic            keep_s;
   logic [NREQ-1:0] gnt_s;
   logic [IW-1:0]   gnt_idx_s;
   logic            any_gnt_s;
   logic            sel_we_s;
   logic [AW-1:0]   sel_addr_s;
   logic [DW-1:0]   sel_wdata_s;

   rr_pick u_pick (
      .req  (req),
      .last (last_r),
      .pick (pick_s)
   );

   // Grant: the current owner keeps the bank until it drops req or exceeds its burst while others wait.
   always_comb begin
      owner_oh_s  = idx_to_onehot(owner_r);
      other_req_s = |(req & ~owner_oh_s);
      keep_s      = (state_r == ST_OWNED) && req[owner_r] &&
                    ((burst_cnt_r < CW'(MAX_BURST)) || !other_req_s);
      if (rst) begin
         gnt_s = {NREQ{1'b0}};
      end else if (keep_s) begin
         gnt_s = owner_oh_s;
      end else begin
         gnt_s = pick_s;
      end
      gnt_idx_s = onehot_to_idx(gnt_s);
      any_gnt_s = |gnt_s;
   end

   // Route the granted requester's command fields to the bank.
   always_comb begin
      sel_we_s    = 1'b0;
      sel_addr_s  = {AW{1'b0}};
      sel_wdata_s = {DW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_s[i]) begin
            sel_we_s    = we[i];
            sel_addr_s  = addr[i*AW +: AW];
            sel_wdata_s = wdata[i*DW +: DW];
         end else begin
            sel_we_s = sel_we_s;
         end
      end
   end

   // Ownership state, burst counting and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         owner_r     <= {IW{1'b0}};
         burst_cnt_r <= {CW{1'b0}};
         last_r      <= IW'(NREQ - 1);
      end else if (any_gnt_s) begin
         last_r  <= gnt_idx_s;
         state_r <= ST_OWNED;
         if (gnt_idx_s == owner_r) begin
            burst_cnt_r <= sat_inc(burst_cnt_r);
         end else begin
            owner_r     <= gnt_idx_s;
            burst_cnt_r <= CW'(1);
         end
      end else begin
         state_r     <= ST_IDLE;
         burst_cnt_r <= {CW{1'b0}};
      end
   end

   // Bank storage and registered read port; reset wins over the access of that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            bank_r[k] <= {DW{1'b0}};
         end
         rdata_r  <= {DW{1'b0}};
         rvalid_r <= {NREQ{1'b0}};
      end else if (any_gnt_s && sel_we_s) begin
         bank_r[sel_addr_s] <= sel_wdata_s;
         rvalid_r           <= {NREQ{1'b0}};
      end else if (any_gnt_s) begin
         rdata_r  <= bank_r[sel_addr_s];
         rvalid_r <= gnt_s;
      end else begin
         rvalid_r <= {NREQ{1'b0}};
      end
   end

   assign gnt    = gnt_s;
   assign rdata  = rdata_r;
   assign rvalid = rvalid_r;
   assign busy   = (state_r == ST_OWNED);

endmodule

// File: tb/tb_data_bank_arbiter.sv
// Directed, table-driven bench for data_bank_arbiter.
module tb_data_bank_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req;
   logic [2:0]  we;
   logic [5:0]  addr;
   logic [23:0] wdata;
   logic [2:0]  gnt;
   logic [7:0]  rdata;
   logic [2:0]  rvalid;
   logic        busy;

   int passed;
   int total;

   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [2:0]  we;
      logic [5:0]  addr;
      logic [23:0] wdata;
      logic [2:0]  gnt;
      logic [2:0]  rvalid;
      logic [7:0]  rdata;
      logic        busy;
   } vec_t;

   vec_t vecs[$];

   data_bank_arbiter dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .we     (we),
      .addr   (addr),
      .wdata  (wdata),
      .gnt    (gnt),
      .rdata  (rdata),
      .rvalid (rvalid),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [2:0] q, input logic [2:0] w,
                               input logic [5:0] a, input logic [23:0] d, input logic [2:0] g,
                               input logic [2:0] rv, input logic [7:0] rd, input logic b);
      vec_t v;
      v.rst = r; v.req = q; v.we = w; v.addr = a; v.wdata = d;
      v.gnt = g; v.rvalid = rv; v.rdata = rd; v.busy = b;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end else begin
         passed++;
      end
   endtask

   // Drive one cycle of inputs just after the edge, return at the following falling edge.
   task automatic apply(input logic r, input logic [2:0] q, input logic [2:0] w,
                        input logic [5:0] a, input logic [23:0] d);
      @(posedge clk);
      #1;
      rst = r; req = q; we = w; addr = a; wdata = d;
      @(negedge clk);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst = 1'b1; req = 3'b000; we = 3'b000; addr = 6'h00; wdata = 24'h000000;

      // reset held two cycles with requests pending: no grant
      vecs.push_back(mk(1'b1, 3'b111, 3'b000, 6'h00, 24'h0, 3'b000, 3'b000, 8'h00, 1'b0));
      vecs.push_back(mk(1'b1, 3'b111, 3'b000, 6'h00, 24'h0, 3'b000, 3'b000, 8'h00, 1'b0));
      vecs.push_back(mk(1'b0, 3'b000, 3'b000, 6'h00, 24'h0, 3'b000, 3'b000, 8'h00, 1'b0));
      // all three reading: 0 x4, 1 x4, 2 x4, then back to 0
      for (int i = 0; i < 13; i++) begin
         logic [2:0] g;
         logic [2:0] rv;
         g  = (i < 4) ? 3'b001 : (i < 8) ? 3'b010 : (i < 12) ? 3'b100 : 3'b001;
         rv = (i == 0) ? 3'b000 : (i < 5) ? 3'b001 : (i < 9) ? 3'b010 : 3'b100;
         vecs.push_back(mk(1'b0, 3'b111, 3'b000, 6'h00, 24'h0, g, rv, 8'h00, (i != 0)));
      end
      vecs.push_back(mk(1'b0, 3'b000, 3'b000, 6'h00, 24'h0, 3'b000, 3'b001, 8'h00, 1'b1));
      vecs.push_back(mk(1'b0, 3'b000, 3'b000, 6'h00, 24'h0, 3'b000, 3'b000, 8'h00, 1'b0));
      // read every word after reset: all zero
      vecs.push_back(mk(1'b0, 3'b001, 3'b000, 6'h00, 24'h0, 3'b001, 3'b000, 8'h00, 1'b0));
      vecs.push_back(mk(1'b0, 3'b001, 3'b000, 6'h01, 24'h0, 3'b001, 3'b001, 8'h00, 1'b1));
      vecs.push_back(mk(1'b0, 3'b001, 3'b000, 6'h02, 24'h0, 3'b001, 3'b001, 8'h00, 1'b1));
      vecs.push_back(mk(1'b0, 3'b001, 3'b000, 6'h03, 24'h0, 3'b001, 3'b001, 8'h00, 1'b1));
      vecs.push_back(mk(1'b0, 3'b000, 3'b000, 6'h00, 24'h0, 3'b000, 3'b001, 8'h00, 1'b1));

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
         check($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vecs[i].rvalid));
         check($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].rdata));
         check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      end

      // write A5 to word 2 by requester 1; requester 0 inputs set but not requesting
      apply(1'b0, 3'b010, 3'b011, 6'h0A, 24'h00A5FF);
      check("raw wr gnt", 32'(gnt), 32'(3'b010));
      apply(1'b0, 3'b001, 3'b000, 6'h02, 24'h000000);
      check("raw rd gnt", 32'(gnt), 32'(3'b001));
      apply(1'b0, 3'b000, 3'b000, 6'h00, 24'h000000);
      check("raw rvalid", 32'(rvalid), 32'(3'b001));
      check("raw rdata", 32'(rdata), 32'(8'hA5));

      // requester 2 alone for 10 cycles reading word 2
      for (int c = 0; c < 10; c++) begin
         apply(1'b0, 3'b100, 3'b000, 6'h20, 24'h000000);
         check($sformatf("solo c%0d gnt", c), 32'(gnt), 32'(3'b100));
         if (c > 0) begin
            check($sformatf("solo c%0d rvalid", c), 32'(rvalid), 32'(3'b100));
            check($sformatf("solo c%0d rdata", c), 32'(rdata), 32'(8'hA5));
         end else begin
            check("solo c0 rvalid", 32'(rvalid), 32'(3'b000));
         end
      end
      // counter saturated: a new requester takes over immediately
      apply(1'b0, 3'b101, 3'b000, 6'h20, 24'h000000);
      check("sat yield gnt", 32'(gnt), 32'(3'b001));

      // owner 0 drops mid-burst, requester 2 takes over in the same cycle
      apply(1'b0, 3'b101, 3'b000, 6'h20, 24'h000000);
      check("drop keep gnt", 32'(gnt), 32'(3'b001));
      apply(1'b0, 3'b100, 3'b000, 6'h20, 24'h000000);
      check("drop swap gnt", 32'(gnt), 32'(3'b100));
      check("drop busy", 32'(busy), 32'(1'b1));
      for (int c = 0; c < 3; c++) begin
         apply(1'b0, 3'b101, 3'b000, 6'h20, 24'h000000);
         check($sformatf("new burst c%0d gnt", c), 32'(gnt), 32'(3'b100));
      end
      apply(1'b0, 3'b101, 3'b000, 6'h20, 24'h000000);
      check("new burst end gnt", 32'(gnt), 32'(3'b001));
      apply(1'b0, 3'b000, 3'b000, 6'h00, 24'h000000);

      // reset lands on a write of 3C by owner 1
      apply(1'b0, 3'b010, 3'b010, 6'h0C, 24'h001100);
      check("rst pre gnt", 32'(gnt), 32'(3'b010));
      apply(1'b1, 3'b010, 3'b010, 6'h0C, 24'h003C00);
      check("rst gnt", 32'(gnt), 32'(3'b000));
      apply(1'b0, 3'b011, 3'b000, 6'h0B, 24'h000000);
      check("rst post gnt", 32'(gnt), 32'(3'b001));
      check("rst post busy", 32'(busy), 32'(1'b0));
      check("rst post rvalid", 32'(rvalid), 32'(3'b000));
      apply(1'b0, 3'b010, 3'b000, 6'h0B, 24'h000000);
      check("rst w3 gnt", 32'(gnt), 32'(3'b010));
      check("rst w3 rvalid", 32'(rvalid), 32'(3'b001));
      check("rst w3 rdata", 32'(rdata), 32'(8'h00));
      apply(1'b0, 3'b000, 3'b000, 6'h00, 24'h000000);
      check("rst w2 rvalid", 32'(rvalid), 32'(3'b010));
      check("rst w2 rdata", 32'(rdata), 32'(8'h00));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
